// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one memory-mapped bus among NUM_MASTERS requesters.
// It runs one transaction at a time and ends it with an ack, or with an error if no slave answers in time.
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_MASTERS-1:0]            i_m_req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_wdata,
  input  logic [NUM_MASTERS-1:0]            i_m_rnw,
  output logic [NUM_MASTERS-1:0]            o_m_ack,
  output logic [NUM_MASTERS-1:0]            o_m_err,
  output logic [DATA_WIDTH-1:0]             o_m_rdata,
  output logic [ADDR_WIDTH-1:0]             o_bus_address,
  output logic [DATA_WIDTH-1:0]             o_bus_wdata,
  output logic                              o_bus_rnw,
  output logic                              o_bus_valid,
  input  logic                              i_bus_ack,
  input  logic [DATA_WIDTH-1:0]             i_bus_rdata
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rnw_q, rnw_d;
  logic [NUM_MASTERS-1:0]  ack_q, ack_d;
  logic [NUM_MASTERS-1:0]  err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0]   m_addr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   m_wdata [NUM_MASTERS];
  logic [IDX_W-1:0]        pick;
  logic                    pick_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign m_addr[gi]  = i_m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign m_wdata[gi] = i_m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Index k steps after base, wrapped into 0..NUM_MASTERS-1 (k is at most NUM_MASTERS).
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return IDX_W'(s);
  endfunction

  // Scanning from the farthest candidate back to the nearest lets the nearest requester win.
  always_comb begin
    pick       = last_grant_q;
    pick_valid = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (i_m_req[rr_idx(last_grant_q, k)]) begin
        pick       = rr_idx(last_grant_q, k);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rnw_d        = rnw_q;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = BUS;
          last_grant_d = pick;
          cnt_d        = '0;
          addr_d       = m_addr[pick];
          wdata_d      = m_wdata[pick];
          rnw_d        = i_m_rnw[pick];
        end
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the final timeout cycle still completes normally.
        if (i_bus_ack) begin
          state_d              = RESP;
          ack_d[last_grant_q]  = 1'b1;
          rdata_d              = i_bus_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d              = RESP;
          err_d[last_grant_q]  = 1'b1;
          rdata_d              = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rnw_q        <= 1'b1;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rnw_q        <= rnw_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_bus_valid   = (state_q == BUS);
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_bus_rnw     = rnw_q;
  assign o_m_ack       = ack_q;
  assign o_m_err       = err_q;
  assign o_m_rdata     = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed master/slave scenarios checked against a transaction-level
// model every cycle, plus literal expectations for each scenario.
module tb_bus_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_req;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_rnw;
  logic [NM-1:0]    m_ack, m_err;
  logic [DW-1:0]    m_rdata;
  logic [AW-1:0]    bus_addr;
  logic [DW-1:0]    bus_wdata;
  logic             bus_rnw, bus_valid, bus_ack;
  logic [DW-1:0]    bus_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_req(m_req), .i_m_address(m_addr), .i_m_wdata(m_wdata), .i_m_rnw(m_rnw),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_rdata(m_rdata),
    .o_bus_address(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_rnw(bus_rnw),
    .o_bus_valid(bus_valid), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one transaction at a time; the bus stays valid for the cycles until ack
  // or until TO cycles have elapsed, then one response cycle, then one idle cycle.
  int             mdl_ptr, mdl_cur, mdl_bus_cycles;
  bit             mdl_busy, mdl_resp;
  logic [NM-1:0]  mdl_ack, mdl_err;
  logic [DW-1:0]  mdl_rdata;
  logic [AW-1:0]  mdl_addr;
  logic [DW-1:0]  mdl_wdata;
  logic           mdl_rnw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_ptr = NM - 1; mdl_busy = 0; mdl_resp = 0; mdl_bus_cycles = 0; mdl_cur = 0;
      mdl_ack = '0; mdl_err = '0; mdl_rdata = '0;
      mdl_addr = '0; mdl_wdata = '0; mdl_rnw = 1'b1;
    end else if (mdl_resp) begin
      mdl_resp = 0; mdl_ack = '0; mdl_err = '0;
    end else if (mdl_busy) begin
      mdl_bus_cycles++;
      if (bus_ack) begin
        mdl_busy = 0; mdl_resp = 1; mdl_ack[mdl_cur] = 1'b1; mdl_rdata = bus_rdata;
      end else if (mdl_bus_cycles == TO) begin
        mdl_busy = 0; mdl_resp = 1; mdl_err[mdl_cur] = 1'b1; mdl_rdata = '0;
      end
    end else begin
      int start;
      start = mdl_ptr;
      for (int k = 1; k <= NM; k++) begin
        int m;
        m = (start + k) % NM;
        if (!mdl_busy && m_req[m]) begin
          mdl_busy = 1; mdl_cur = m; mdl_ptr = m; mdl_bus_cycles = 0;
          mdl_addr  = m_addr[m*AW +: AW];
          mdl_wdata = m_wdata[m*DW +: DW];
          mdl_rnw   = m_rnw[m];
        end
      end
    end
  end

  always @(negedge clk) begin
    check("valid", bus_valid, mdl_busy);
    check("ack", m_ack, mdl_ack);
    check("err", m_err, mdl_err);
    if (mdl_busy) begin
      check("bus_addr", bus_addr, mdl_addr);
      check("bus_wdata", bus_wdata, mdl_wdata);
      check("bus_rnw", bus_rnw, mdl_rnw);
    end
    if (|mdl_ack || |mdl_err) check("rdata", m_rdata, mdl_rdata);
  end

  // Monitor: running tallies and one line per completed transaction.
  int mon_valid = 0, mon_acks = 0, mon_errs = 0;
  logic [NM-1:0] mon_ack_vec = '0, mon_err_vec = '0;
  logic [DW-1:0] mon_ack_rdata = '0, mon_err_rdata = '0;
  int grant_q[$];
  int ack_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_valid === 1'b1) mon_valid++;
    if (|m_ack) begin
      mon_acks++; mon_ack_vec = m_ack; mon_ack_rdata = m_rdata;
      for (int i = 0; i < NM; i++) if (m_ack[i]) grant_q.push_back(i);
      ack_cyc_q.push_back(cyc);
      $display("txn: cycle %0d ack=%b rdata=%h", cyc, m_ack, m_rdata);
    end
    if (|m_err) begin
      mon_errs++; mon_err_vec = m_err; mon_err_rdata = m_rdata;
      $display("txn: cycle %0d err=%b rdata=%h", cyc, m_err, m_rdata);
    end
  end

  task automatic set_master(input int m, input logic req, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic rnw);
    m_req[m] = req;
    m_addr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW] = d;
    m_rnw[m] = rnw;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus_valid === 1'b1) ok = 1;
    end
    check({name, "_valid_seen"}, ok, 1'b1);
  endtask

  // Slave acks during the n-th BUS cycle; returns at the response-cycle negedge.
  task automatic slave_ack(input string name, input int n, input logic [DW-1:0] d);
    wait_valid(name);
    repeat (n - 1) @(negedge clk);
    bus_ack = 1'b1; bus_rdata = d;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic reset_checks(input string name);
    check({name, "_valid"}, bus_valid, 1'b0);
    check({name, "_addr"}, bus_addr, 32'h0);
    check({name, "_wdata"}, bus_wdata, 32'h0);
    check({name, "_rnw"}, bus_rnw, 1'b1);
    check({name, "_ack"}, m_ack, 4'b0000);
    check({name, "_err"}, m_err, 4'b0000);
    check({name, "_rdata"}, m_rdata, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req = '0; m_addr = '0; m_wdata = '0; m_rnw = '1;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #30000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv, ba, be, qb;
    do_reset();

    // Single read by master 2, acked in the third BUS cycle.
    bv = mon_valid; ba = mon_acks; be = mon_errs;
    set_master(2, 1'b1, 32'h0000_0010, 32'h0, 1'b1);
    slave_ack("t1", 3, 32'hDEAD_BEEF);
    m_req[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_valid_cycles", mon_valid - bv, 3);
    check("t1_ack_count", mon_acks - ba, 1);
    check("t1_ack_vec", mon_ack_vec, 4'b0100);
    check("t1_rdata", mon_ack_rdata, 32'hDEAD_BEEF);
    check("t1_no_err", mon_errs - be, 0);

    // All four request continuously; immediate acks rotate 0,1,2,3 every 3 cycles.
    do_reset();
    for (int m = 0; m < NM; m++) set_master(m, 1'b1, 32'h100 * (m + 1), 32'h0, 1'b1);
    qb = grant_q.size();
    for (int k = 0; k < 8; k++) slave_ack("t2", 1, 32'hA000_0000 + k);
    m_req = '0;
    repeat (2) @(negedge clk);
    check("t2_grant_count", grant_q.size() - qb, 8);
    if (grant_q.size() - qb == 8) begin
      for (int k = 0; k < 8; k++) check("t2_grant_order", grant_q[qb + k], k % 4);
      for (int k = 1; k < 8; k++)
        check("t2_spacing", ack_cyc_q[qb + k] - ack_cyc_q[qb + k - 1], 3);
    end

    // Stray ack while idle is ignored; then master 1 writes to an unmapped address.
    bv = mon_valid; ba = mon_acks; be = mon_errs;
    bus_ack = 1'b1;
    repeat (2) @(negedge clk);
    bus_ack = 1'b0;
    set_master(1, 1'b1, 32'hFFFF_0000, 32'h55, 1'b0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (|m_err) seen = 1;
      end
      check("t3_err_seen", seen, 1'b1);
    end
    m_req[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_valid_cycles", mon_valid - bv, 16);
    check("t3_err_vec", mon_err_vec, 4'b0010);
    check("t3_err_rdata", mon_err_rdata, 32'h0);
    check("t3_no_ack", mon_acks - ba, 0);
    check("t3_err_count", mon_errs - be, 1);

    // Ack in the last possible BUS cycle beats the timeout.
    bv = mon_valid; ba = mon_acks; be = mon_errs;
    set_master(3, 1'b1, 32'h0000_2000, 32'h0, 1'b1);
    slave_ack("t4", 16, 32'h1234_5678);
    m_req[3] = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_valid_cycles", mon_valid - bv, 16);
    check("t4_ack_vec", mon_ack_vec, 4'b1000);
    check("t4_rdata", mon_ack_rdata, 32'h1234_5678);
    check("t4_no_err", mon_errs - be, 0);

    // Master 0 withdraws and scrambles its fields mid-BUS; the captured write still completes.
    set_master(0, 1'b1, 32'h3000_0040, 32'h0000_CAFE, 1'b0);
    wait_valid("t5");
    set_master(0, 1'b0, 32'hBAD0_0000, 32'h1111_1111, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_addr_held", bus_addr, 32'h3000_0040);
    check("t5_wdata_held", bus_wdata, 32'h0000_CAFE);
    check("t5_rnw_held", bus_rnw, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'h0;
    @(negedge clk);
    bus_ack = 1'b0;
    check("t5_ack", m_ack, 4'b0001);
    repeat (2) @(negedge clk);

    // Reset two cycles into a transaction for master 1; afterwards master 0 wins.
    ba = mon_acks; be = mon_errs;
    set_master(1, 1'b1, 32'h0000_4000, 32'h0, 1'b1);
    wait_valid("t6");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    reset_checks("t6_async");
    set_master(0, 1'b1, 32'h0000_5000, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("t6_no_ack_on_reset", mon_acks - ba, 0);
    check("t6_no_err_on_reset", mon_errs - be, 0);
    wait_valid("t6b");
    check("t6_master0_first", bus_addr, 32'h0000_5000);
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus_ack = 1'b0;
    m_req = '0;
    check("t6_ack", m_ack, 4'b0001);
    check("t6_rdata", m_rdata, 32'h0BAD_F00D);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one memory-mapped bus among `NUM_MASTERS` requesters. It sits between the masters (CPU, DMA, debug bridge) and the shared address/data bus whose slaves are selected by the address-decode chip selects. It owns the bus for one transaction at a time and returns read data or an error to the requester. A timeout counter terminates transactions that no slave acknowledges, such as unmapped addresses where no chip select fires.

## Interface
- `NUM_MASTERS`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, bus data width
- `TIMEOUT`, 16, cycles in BUS without `i_bus_ack` before error termination (≥2)

Ports:
- `i_clk`  in  1  clock; all logic on rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_m_req`  in  NUM_MASTERS  per-master request; held with its fields until that master's `o_m_ack` or `o_m_err`
- `i_m_address`  in  NUM_MASTERS*ADDR_WIDTH  per-master address; master m at bits [m*ADDR_WIDTH +: ADDR_WIDTH]
- `i_m_wdata`  in  NUM_MASTERS*DATA_WIDTH  per-master write data, packed the same way
- `i_m_rnw`  in  NUM_MASTERS  1 = read, 0 = write
- `o_m_ack`  out  NUM_MASTERS  one-cycle completion pulse to the granted master
- `o_m_err`  out  NUM_MASTERS  one-cycle timeout pulse to the granted master
- `o_m_rdata`  out  DATA_WIDTH  read data; valid while `o_m_ack` is high
- `o_bus_address`  out  ADDR_WIDTH  shared bus address; drives the decode chip selects
- `o_bus_wdata`  out  DATA_WIDTH  shared bus write data
- `o_bus_rnw`  out  1  shared bus direction
- `o_bus_valid`  out  1  address on bus is valid; feeds the chip select `i_data_valid`
- `i_bus_ack`  in  1  selected slave completed the transaction
- `i_bus_rdata`  in  DATA_WIDTH  slave read data, sampled when `i_bus_ack` is high

## Operation
- FSM states and transitions:
  - IDLE → BUS when any `i_m_req` is high.
  - BUS → RESP on `i_bus_ack`, or when the timeout count reaches `TIMEOUT-1` without an ack.
  - RESP → IDLE unconditionally.
- Arbitration happens only in IDLE:
  - Search starts at `(last_grant+1) mod NUM_MASTERS` and picks the first master with its request high.
  - `grant` and `last_grant` are registered on IDLE→BUS.
  - `last_grant` resets to `NUM_MASTERS-1`, so master 0 has first priority after reset.
- Bus capture on IDLE→BUS: the granted master's address, wdata and rnw are registered onto the `o_bus_*` outputs and held constant throughout BUS.
- `o_bus_valid` is high exactly while in BUS.
- Timeout counter:
  - Clears on entry to BUS and increments each BUS cycle; width is `$clog2(TIMEOUT)`.
  - If `i_bus_ack` is high in the same cycle the count reaches `TIMEOUT-1`, the ack wins: `o_m_ack` fires, not `o_m_err`.
- On BUS→RESP with ack: `i_bus_rdata` is registered into `o_m_rdata`, and `o_m_ack[grant]` is high during RESP.
- On BUS→RESP by timeout: `o_m_err[grant]` is high during RESP and `o_m_rdata` is 0.
- In RESP, `o_m_ack`/`o_m_err` are one-hot for one cycle; all other masters see 0.
- Requests are ignored while in BUS or RESP.
- `i_m_req` dropping mid-transaction does not abort it; the transaction completes normally.
- `i_bus_ack` outside BUS is ignored.
- Writes acknowledge identically to reads; `o_m_rdata` is don't-care for writes but is still registered.

## Timing
- Reset values (asynchronous): state = IDLE, `o_bus_valid` = 0, `o_bus_address` = 0, `o_bus_wdata` = 0, `o_bus_rnw` = 1, `o_m_ack` = 0, `o_m_err` = 0, `o_m_rdata` = 0, `last_grant` = `NUM_MASTERS-1`, counter = 0.
- A request seen in IDLE at edge 0 gives `o_bus_valid` high after edge 0.
- `i_bus_ack` sampled high at edge k gives `o_m_ack` high for the cycle after edge k.
- The next `o_bus_valid` rises at edge k+2 at the earliest.
- Minimum occupancy is 3 cycles per transaction (IDLE, BUS, RESP).
- With no ack, `o_bus_valid` stays high for exactly `TIMEOUT` cycles, then `o_m_err` is high for 1 cycle.
- A master sees `o_m_ack`/`o_m_err` and may present a new request in the same cycle. That request is sampled in the following IDLE and arbitrated fairly against the other masters.
- Reset asserted mid-BUS drops `o_bus_valid` immediately (asynchronously) and no ack or error is issued.

## Test plan
- Reset then single request: master 2 reads 0x0000_0010 and the slave acks 3 cycles after valid with rdata 0xDEAD_BEEF. Required: `o_m_ack` = 4'b0100 for 1 cycle with `o_m_rdata` = 0xDEAD_BEEF, and `o_bus_valid` high for 3 cycles.
- All four masters request continuously and the slave acks in the first BUS cycle. Required: grant order is 0,1,2,3,0,… with 3 cycles per grant.
- Master 1 writes 0x55 to an unmapped address with `TIMEOUT`=16 and no ack. Required: `o_bus_valid` high for exactly 16 cycles, then `o_m_err` = 4'b0010 for 1 cycle, `o_m_rdata` = 0, and no ack.
- Ack arrives in the same cycle the count reaches 15. Required: `o_m_ack` fires, `o_m_err` stays 0.
- Master 0 drops `i_m_req` mid-BUS. Required: the bus fields stay stable and the ack is still delivered to master 0.
- `i_rst` is asserted 2 cycles into BUS. Required: all outputs return to reset values before the next clock edge, and after release master 0 has first priority.
